sram_march_bist_ctrl: RTL and testbench
=======================================

Name: sram_march_bist_ctrl

Overview:
- March C- built-in self-test engine that drives the BIST_* port group of one port (A or B) of the 2-port SRAM macros. It checks the returned DOUT against expected data.
- Sits beside each macro. The integrator ties the macro's BIST_CLK to clk_i, and instantiates one controller per port to be tested.
- Reports pass/fail and captures the first failing address, data and March element for the test/DFT controller.

Parameters:
- DW, 32, data and bit-mask width
- AW, 9, address width
- DEPTH, 512, number of words tested (addresses 0..DEPTH-1); 2 <= DEPTH <= 2**AW

Ports:
- clk_i  in  1  clock; also feeds macro BIST_CLK
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  level; sampled in IDLE or DONE to start a run
- bg_i  in  1  background select: 0 = solid (0/1), 1 = checkerboard
- bist_en_o  out  1  to macro BIST_EN; selects BIST port group
- bist_men_o  out  1  to BIST_MEN
- bist_wen_o  out  1  to BIST_WEN
- bist_ren_o  out  1  to BIST_REN
- bist_addr_o  out  AW  to BIST_ADDR
- bist_din_o  out  DW  to BIST_DIN
- bist_bm_o  out  DW  to BIST_BM; constant all-ones
- dout_i  in  DW  from macro DOUT of the same port
- busy_o  out  1  run in progress
- done_o  out  1  run complete; held until next start
- fail_o  out  1  sticky mismatch flag
- fail_addr_o  out  AW  address of first mismatch
- fail_elem_o  out  3  March element (0..5) of first mismatch
- fail_data_o  out  DW  dout_i value at first mismatch

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst_ni=0 at an edge) gives: state IDLE; bist_en/men/wen/ren = 0; addr = 0; din = 0; bist_bm_o = all-ones; busy, done, fail = 0; fail_addr/elem/data = 0. Reset mid-run aborts the run with no drain and drops bist_en_o at that same edge.
- States: IDLE -> RUN -> DRAIN -> DONE.
  - IDLE/DONE with start_i=1 -> RUN. This clears fail_* and done_o, and loads element 0, address 0, op 0.
  - DONE with start_i=0 -> stays in DONE.
- Elements, with direction and ops:
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Up elements start at address 0; down elements start at DEPTH-1.
- One op per cycle, no idle cycles between ops, addresses or elements.
- The address advances after the last op of an element at that address. Wrap to the next element happens after address DEPTH-1 (up) or 0 (down).
- Total op cycles = 10*DEPTH.
- Data value for "0": solid = all-zeros; checkerboard = {DW/2{2'b01}} XOR {DW{addr[0]}}. "1" is the bitwise inverse.
- Per op: bist_men_o = 1, and exactly one of wen/ren = 1. bist_din_o carries the pattern on writes and 0 on reads.
- bist_en_o = busy_o = 1 throughout RUN and DRAIN. Both go to 0 on the edge entering DONE.
- Read latency:
  - A read presented in cycle N is captured by the macro at edge N+1.
  - The controller samples dout_i at edge N+2 against a 2-deep pipeline of {valid, expected, addr, elem}.
- DRAIN: 2 cycles with men/wen/ren = 0, to retire the final reads. Then DONE, with done_o = 1.
- Start at edge S gives done_o = 1 after edge S + 10*DEPTH + 2 + 1.
- Mismatch handling:
  - Any compare with dout_i != expected sets fail_o.
  - fail_addr/elem/data are captured only when fail_o was 0. Later mismatches do not overwrite them.
  - The run always completes; there is no early abort.
- start_i is ignored during RUN and DRAIN.

Test Plan:
- Fault-free memory model, DEPTH=512, bg=0, start pulse at edge S:
  - 5120 op cycles with exact op/addr sequence: E0 addr 0..511 writes 0; E3 first op r0 @511.
  - done_o rises at S+5123; fail_o = 0; bist_en_o low in DONE.
- Stuck-at-1 on bit 5 of addr 0x07B, bg=0:
  - fail_o = 1; fail_addr_o = 0x07B; fail_elem_o = 1; fail_data_o = 0x00000020.
  - Later mismatches (E5) do not change the captured values.
- bg=1, fault-free:
  - write data alternates 0x55555555 (even addr) / 0xAAAAAAAA (odd) in E0; done with fail_o = 0.
- Reset asserted mid-E2:
  - next edge: bist_en/men/wen/ren = 0, state IDLE, fail_o = 0.
  - A fresh start then runs the full 5120+2-cycle sequence from E0 addr 0.
- Restart from DONE after a failed run:
  - start_i=1 clears fail_o and done_o.
  - Second fault-free run ends with fail_o = 0.
  - start_i toggled during RUN has no effect.
- DEPTH=2 instance:
  - exactly 20 op cycles.
  - Down elements visit addr 1 then 0.
  - bist_bm_o is all-ones in every cycle.

Source files
------------

// File: rtl/sram_march_bist_if.sv
// BIST port-group bus between the March C- controller and one port of a 2-port SRAM macro.
interface sram_march_bist_if #(
  parameter int DW = 32,
  parameter int AW = 9
);
  logic          bist_en_o;
  logic          bist_men_o;
  logic          bist_wen_o;
  logic          bist_ren_o;
  logic [AW-1:0] bist_addr_o;
  logic [DW-1:0] bist_din_o;
  logic [DW-1:0] bist_bm_o;
  logic [DW-1:0] dout_i;

  modport master (
    output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
    output bist_addr_o, bist_din_o, bist_bm_o,
    input  dout_i
  );

  modport slave (
    input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
    input  bist_addr_o, bist_din_o, bist_bm_o,
    output dout_i
  );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST engine for one SRAM port: issues one op per cycle, checks read data two
// cycles later and records the first failing address, element and data.
module sram_march_bist_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              bg_i,
  sram_march_bist_if.master bist,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [AW-1:0]     fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [DW-1:0]     fail_data_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] CHECKER   = {(DW/2){2'b01}};

  function automatic logic [DW-1:0] march_pattern(input logic bg, input logic a0,
                                                   input logic one);
    logic [DW-1:0] base;
    base = bg ? (CHECKER ^ {DW{a0}}) : '0;
    return one ? ~base : base;
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic op_is_write(input logic [2:0] e, input logic op);
    return (e == 3'd0) || op;
  endfunction

  // Logical data value (0 or 1) of an op: E1/E3 go r0,w1; E2/E4 go r1,w0; E0/E5 use 0.
  function automatic logic op_value(input logic [2:0] e, input logic op);
    logic v;
    case (e)
      3'd1, 3'd3: v = op;
      3'd2, 3'd4: v = ~op;
      default:    v = 1'b0;
    endcase
    return v;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          op_q, op_d;
  logic [1:0]    drain_q, drain_d;
  logic          bg_q, bg_d;

  logic          en_q, en_d;
  logic          men_q, men_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [DW-1:0] din_q, din_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]    fail_elem_q, fail_elem_d;
  logic [DW-1:0] fail_data_q, fail_data_d;

  logic          vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [DW-1:0] exp_p0_q, exp_p0_d, exp_p1_q, exp_p1_d;
  logic [AW-1:0] addr_p0_q, addr_p0_d, addr_p1_q, addr_p1_d;
  logic [2:0]    elem_p0_q, elem_p0_d, elem_p1_q, elem_p1_d;

  logic          is_wr;
  logic [DW-1:0] pat;
  logic [2:0]    elem_nxt;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    op_d        = op_q;
    drain_d     = drain_q;
    bg_d        = bg_q;
    en_d        = en_q;
    men_d       = 1'b0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    baddr_d     = baddr_q;
    din_d       = '0;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    vld_p0_d    = 1'b0;
    exp_p0_d    = exp_p0_q;
    addr_p0_d   = addr_p0_q;
    elem_p0_d   = elem_p0_q;
    is_wr       = op_is_write(elem_q, op_q);
    pat         = march_pattern(bg_q, addr_q[0], op_value(elem_q, op_q));
    elem_nxt    = elem_q + 3'd1;

    // Stage p1 -> compare: dout_i now holds the data of the read issued two cycles ago.
    vld_p1_d    = vld_p0_q;
    exp_p1_d    = exp_p0_q;
    addr_p1_d   = addr_p0_q;
    elem_p1_d   = elem_p0_q;
    if (vld_p1_q && (bist.dout_i != exp_p1_q)) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = addr_p1_q;
        fail_elem_d = elem_p1_q;
        fail_data_d = bist.dout_i;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          op_d        = 1'b0;
          bg_d        = bg_i;
          en_d        = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_data_d = '0;
        end
      end
      ST_RUN: begin
        men_d     = 1'b1;
        wen_d     = is_wr;
        ren_d     = ~is_wr;
        baddr_d   = addr_q;
        din_d     = is_wr ? pat : '0;
        // Stage p0: expectation travels with the read just issued.
        vld_p0_d  = ~is_wr;
        exp_p0_d  = pat;
        addr_p0_d = addr_q;
        elem_p0_d = elem_q;
        if (elem_two_ops(elem_q) && !op_q) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (addr_q == (elem_down(elem_q) ? '0 : LAST_ADDR)) begin
            if (elem_q == 3'd5) begin
              state_d = ST_DRAIN;
              drain_d = 2'd0;
            end else begin
              elem_d = elem_nxt;
              addr_d = elem_down(elem_nxt) ? LAST_ADDR : '0;
            end
          end else begin
            addr_d = elem_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      drain_q     <= '0;
      bg_q        <= 1'b0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      baddr_q     <= '0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      vld_p0_q    <= 1'b0;
      exp_p0_q    <= '0;
      addr_p0_q   <= '0;
      elem_p0_q   <= '0;
      vld_p1_q    <= 1'b0;
      exp_p1_q    <= '0;
      addr_p1_q   <= '0;
      elem_p1_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      drain_q     <= drain_d;
      bg_q        <= bg_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      baddr_q     <= baddr_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      vld_p0_q    <= vld_p0_d;
      exp_p0_q    <= exp_p0_d;
      addr_p0_q   <= addr_p0_d;
      elem_p0_q   <= elem_p0_d;
      vld_p1_q    <= vld_p1_d;
      exp_p1_q    <= exp_p1_d;
      addr_p1_q   <= addr_p1_d;
      elem_p1_q   <= elem_p1_d;
    end
  end

  assign bist.bist_en_o   = en_q;
  assign bist.bist_men_o  = men_q;
  assign bist.bist_wen_o  = wen_q;
  assign bist.bist_ren_o  = ren_q;
  assign bist.bist_addr_o = baddr_q;
  assign bist.bist_din_o  = din_q;
  assign bist.bist_bm_o   = '1;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: SRAM models with an injectable stuck-at cell and an
// op-list reference model of March C- built directly from the element table.
module tb_sram_march_bist_ctrl;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int D0 = 512;
  localparam int D1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start0, start1, bg;
  sram_march_bist_if #(.DW(DW), .AW(AW)) b0 ();
  sram_march_bist_if #(.DW(DW), .AW(AW)) b1 ();

  logic          busy0, done0, fail0, busy1, done1, fail1;
  logic [AW-1:0] faddr0, faddr1;
  logic [2:0]    felem0, felem1;
  logic [DW-1:0] fdata0, fdata1;

  sram_march_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(D0)) u_big (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .bg_i(bg), .bist(b0),
    .busy_o(busy0), .done_o(done0), .fail_o(fail0),
    .fail_addr_o(faddr0), .fail_elem_o(felem0), .fail_data_o(fdata0));

  sram_march_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(D1)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .bg_i(bg), .bist(b1),
    .busy_o(busy1), .done_o(done1), .fail_o(fail1),
    .fail_addr_o(faddr1), .fail_elem_o(felem1), .fail_data_o(fdata1));

  // SRAM models: write/read captured at the edge after the op is presented.
  logic [DW-1:0] mem0 [D0];
  logic [DW-1:0] mem1 [D1];
  bit            f_en;
  int            f_addr;
  logic [DW-1:0] f_or, f_and;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    if (f_en && a == f_addr) return (v | f_or) & f_and;
    return v;
  endfunction

  always @(posedge clk) begin
    if (b0.bist_men_o && b0.bist_wen_o) mem0[b0.bist_addr_o] <= b0.bist_din_o;
    if (b0.bist_men_o && b0.bist_ren_o)
      b0.dout_i <= faulty(mem0[b0.bist_addr_o], int'(b0.bist_addr_o));
    if (b1.bist_men_o && b1.bist_wen_o) mem1[b1.bist_addr_o[0]] <= b1.bist_din_o;
    if (b1.bist_men_o && b1.bist_ren_o) b1.dout_i <= mem1[b1.bist_addr_o[0]];
  end

  bit            sel;
  logic          o_en, o_men, o_wen, o_ren, o_busy, o_done, o_fail;
  logic [AW-1:0] o_addr, o_faddr;
  logic [DW-1:0] o_din, o_bm, o_fdata;
  logic [2:0]    o_felem;

  always_comb begin
    if (sel) begin
      o_en = b1.bist_en_o; o_men = b1.bist_men_o; o_wen = b1.bist_wen_o; o_ren = b1.bist_ren_o;
      o_addr = b1.bist_addr_o; o_din = b1.bist_din_o; o_bm = b1.bist_bm_o;
      o_busy = busy1; o_done = done1; o_fail = fail1;
      o_faddr = faddr1; o_felem = felem1; o_fdata = fdata1;
    end else begin
      o_en = b0.bist_en_o; o_men = b0.bist_men_o; o_wen = b0.bist_wen_o; o_ren = b0.bist_ren_o;
      o_addr = b0.bist_addr_o; o_din = b0.bist_din_o; o_bm = b0.bist_bm_o;
      o_busy = busy0; o_done = done0; o_fail = fail0;
      o_faddr = faddr0; o_felem = felem0; o_fdata = fdata0;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // March C- table: op kinds 0=w0 1=w1 2=r0 3=r1, -1 = no op.
  int el_kind [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
  bit el_down [6]    = '{0, 0, 0, 1, 1, 0};

  logic [43:0]   exp_q [$];
  bit            r_fail;
  logic [AW-1:0] r_faddr;
  logic [2:0]    r_felem;
  logic [DW-1:0] r_fdata;

  function automatic logic [DW-1:0] ref_pat(input bit bgv, input int a, input int v);
    logic [DW-1:0] base;
    base = !bgv ? 32'h0000_0000 : ((a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555);
    return (v != 0) ? ~base : base;
  endfunction

  task automatic build_ref(input int depth, input bit bgv, input bit fen);
    logic [DW-1:0] rm [];
    rm = new[depth];
    exp_q.delete();
    r_fail = 1'b0; r_faddr = '0; r_felem = '0; r_fdata = '0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < depth; k++) begin
        int a;
        a = el_down[e] ? depth - 1 - k : k;
        for (int j = 0; j < 2; j++) begin
          int kind;
          logic [DW-1:0] p, rd;
          kind = el_kind[e][j];
          if (kind >= 0) begin
            p = ref_pat(bgv, a, kind % 2);
            if (kind < 2) begin
              rm[a] = p;
              exp_q.push_back({3'b110, AW'(a), p});
            end else begin
              rd = rm[a];
              if (fen && a == f_addr) rd = (rd | f_or) & f_and;
              if (rd != p && !r_fail) begin
                r_fail = 1'b1; r_faddr = AW'(a); r_felem = 3'(e); r_fdata = rd;
              end
              exp_q.push_back({3'b101, AW'(a), {DW{1'b0}}});
            end
          end
        end
      end
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  task automatic run_check(input string name, input bit which, input bit bgv,
                           input bit fen, input bit tog);
    int depth;
    depth = which ? D1 : D0;
    @(negedge clk);
    sel = which;
    bg  = bgv;
    build_ref(depth, bgv, fen);
    set_start(1'b1);
    @(posedge clk);
    #1;
    if (!tog) set_start(1'b0);
    @(negedge clk);
    chk({name, "_start_stat"}, {o_busy, o_done, o_fail, o_men}, 4'b1000);
    for (int i = 0; i < 10 * depth; i++) begin
      @(negedge clk);
      chk({name, "_op"}, {o_men, o_wen, o_ren, o_addr, o_din}, exp_q[i]);
      chk({name, "_run_stat"}, {o_en, o_busy, o_done, o_bm}, {3'b110, {DW{1'b1}}});
      if (tog) set_start((i == 10 * depth - 1) ? 1'b0 : 1'($urandom_range(1, 0)));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({name, "_drain"}, {o_men, o_wen, o_ren, o_en, o_busy, o_done}, 6'b000110);
    end
    @(negedge clk);
    chk({name, "_done_stat"}, {o_en, o_busy, o_done}, 3'b001);
    chk({name, "_fail"}, o_fail, r_fail);
    chk({name, "_faddr"}, o_faddr, r_faddr);
    chk({name, "_felem"}, o_felem, r_felem);
    chk({name, "_fdata"}, o_fdata, r_fdata);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ctl"}, {o_en, o_men, o_wen, o_ren, o_busy, o_done, o_fail}, 7'b0);
    chk({name, "_addr"}, o_addr, '0);
    chk({name, "_din"}, o_din, '0);
    chk({name, "_bm"}, o_bm, {DW{1'b1}});
    chk({name, "_finfo"}, {o_faddr, o_felem, o_fdata}, '0);
  endtask

  initial begin
    int bitn;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; bg = 1'b0; sel = 1'b0;
    f_en = 1'b0; f_addr = 0; f_or = '0; f_and = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #1 check_reset_state("rst_big");
    sel = 1'b1; #1 check_reset_state("rst_small");
    @(negedge clk);
    rst_n = 1'b1;

    run_check("ff_bg0", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stuck-at-1 on bit 5 of word 0x07B.
    f_en = 1'b1; f_addr = 'h7B; f_or = 32'h0000_0020; f_and = '1;
    run_check("sa1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sa1_fixed_fail", fail0, 1'b1);
    chk("sa1_fixed_addr", faddr0, 9'h07B);
    chk("sa1_fixed_elem", felem0, 3'd1);
    chk("sa1_fixed_data", fdata0, 32'h0000_0020);
    repeat (3) @(negedge clk);
    chk("done_hold", {done0, busy0, fail0}, 3'b101);

    // Restart from a failed DONE with start toggling during the run.
    f_en = 1'b0;
    run_check("restart", 1'b0, 1'b0, 1'b0, 1'b1);

    run_check("ff_bg1", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of E2 (ops 1536..2559) after an E1 mismatch has set fail_o.
    f_en = 1'b1; f_addr = 'h7B; f_or = 32'h0000_0020; f_and = '1;
    @(negedge clk);
    sel = 1'b0; bg = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (1700) @(posedge clk);
    @(negedge clk);
    chk("mid_e2_fail", fail0, 1'b1);
    chk("mid_e2_busy", {b0.bist_en_o, busy0}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctl", {b0.bist_en_o, b0.bist_men_o, b0.bist_wen_o, b0.bist_ren_o,
                        busy0, done0, fail0}, 7'b0);
    rst_n = 1'b1;
    f_en = 1'b0;
    run_check("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Random single stuck-at cells with random background.
    for (int r = 0; r < 2; r++) begin
      f_en   = 1'b1;
      f_addr = int'($urandom_range(D0 - 1, 0));
      bitn   = int'($urandom_range(DW - 1, 0));
      if ($urandom_range(1, 0) == 1) begin
        f_or = DW'(1) << bitn; f_and = '1;
      end else begin
        f_or = '0; f_and = ~(DW'(1) << bitn);
      end
      run_check("rnd", 1'b0, 1'($urandom_range(1, 0)), 1'b1, 1'b0);
    end
    f_en = 1'b0;

    run_check("d2_bg0", 1'b1, 1'b0, 1'b0, 1'b0);
    run_check("d2_bg1", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
